code_modulator: RTL and testbench

Spread-spectrum transmitter for the phase-DSP link: accepts bytes over a valid/ready handshake and serialises each bit as one code word of chips (the code for a 1, its bitwise inverse for a 0). The output is a single-bit chip stream that drives the TX line/LVDS driver. The far-end digitizer and correlator pair (code 1 / code 0) recovers it. Each burst begins with a fixed preamble of 1-bits so the receiving correlators can lock before data.

---
 rtl/phase_dsp_pkg.sv | 8 +
 rtl/code_modulator_chip_timer.sv | 34 +++
 rtl/code_modulator.sv | 93 +++++++++
 tb/tb_code_modulator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/phase_dsp_pkg.sv
// phase_dsp_pkg: shared state encoding and default spreading code for the phase-DSP link.
package phase_dsp_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_e;
  localparam logic [7:0] DEFAULT_CODE = 8'b10110010;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/code_modulator_chip_timer.sv
// chip_timer: clock-divider and chip-index counter pair producing chip and bit boundaries.
module chip_timer #(
  parameter int CODE_LEN = 8,
  parameter int CHIP_DIV = 16,
  parameter int IDX_W = 3,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             chip_end_o,
  output logic             bit_end_o,
  output logic [IDX_W-1:0] chip_idx_o
);
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  assign chip_end_o = div_q == DIV_W'(CHIP_DIV - 1);
  assign bit_end_o = chip_end_o & (idx_q == IDX_W'(CODE_LEN - 1));
  assign chip_idx_o = idx_q;
  always_comb begin
    div_d = clr_i ? '0 : !en_i ? div_q : chip_end_o ? '0 : div_q + DIV_W'(1);
    idx_d = clr_i ? '0 : !(en_i & chip_end_o) ? idx_q : bit_end_o ? '0 : idx_q + IDX_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/code_modulator.sv
// code_modulator: serialises bytes into a direct-sequence chip stream, preceded by a 1-bit preamble per burst.
module code_modulator
  import phase_dsp_pkg::*;
#(
  parameter int CODE_LEN = 8,
  parameter logic [CODE_LEN-1:0] CODE = CODE_LEN'(DEFAULT_CODE),
  parameter int CHIP_DIV = 16,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       sig_out,
  output logic       tx_en
);
  localparam int IDX_W = cnt_w(CODE_LEN);
  localparam int DIV_W = cnt_w(CHIP_DIV);
  localparam int PRE_W = cnt_w(PREAMBLE_BITS);
  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             sig_q, tx_q;
  logic             chip_end, bit_end, byte_end, xfer, clr, en, pre_last, cur_bit, chip_d;
  logic [IDX_W-1:0] chip_idx, idx_nxt, code_pos;
  chip_timer #(.CODE_LEN(CODE_LEN), .CHIP_DIV(CHIP_DIV), .IDX_W(IDX_W), .DIV_W(DIV_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .en_i      (en),
    .chip_end_o(chip_end),
    .bit_end_o (bit_end),
    .chip_idx_o(chip_idx)
  );
  assign en = state_q != IDLE;
  assign byte_end = bit_end & (bit_idx_q == 3'd7) & (state_q == DATA);
  assign data_ready = (state_q == IDLE) | byte_end;
  assign xfer = data_valid & data_ready;
  assign clr = xfer & (state_q == IDLE);
  assign pre_last = pre_q == PRE_W'(PREAMBLE_BITS - 1);
  assign sig_out = sig_q;
  assign tx_en = tx_q;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_idx_d = bit_idx_q;
    pre_d = pre_q;
    if (state_q == IDLE) begin
      if (xfer) begin
        shift_d = data_in;
        bit_idx_d = '0;
        pre_d = '0;
        state_d = PREAMBLE_BITS > 0 ? PREAMBLE : DATA;
      end
    end else if (state_q == PREAMBLE) begin
      if (bit_end) begin
        pre_d = pre_last ? '0 : pre_q + PRE_W'(1);
        state_d = pre_last ? DATA : PREAMBLE;
      end
    end else if (byte_end) begin
      shift_d = xfer ? data_in : shift_q;
      bit_idx_d = '0;
      state_d = xfer ? DATA : IDLE;
    end else if (bit_end) begin
      shift_d = {shift_q[6:0], 1'b0};
      bit_idx_d = bit_idx_q + 3'd1;
    end
    // Outputs are registered, so the chip is derived from where the timer lands next cycle.
    idx_nxt = (clr | bit_end) ? '0 : (en & chip_end) ? chip_idx + IDX_W'(1) : chip_idx;
    code_pos = IDX_W'(CODE_LEN - 1) - idx_nxt;
    cur_bit = state_d == DATA ? shift_d[7] : 1'b1;
    chip_d = CODE[code_pos] ~^ cur_bit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_idx_q <= '0;
      pre_q <= '0;
      sig_q <= 1'b0;
      tx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_idx_q <= bit_idx_d;
      pre_q <= pre_d;
      sig_q <= (state_d != IDLE) & chip_d;
      tx_q <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_code_modulator.sv
// tb_code_modulator: randomized bench comparing two modulator configurations against a per-cycle chip-queue model.
module tb_code_modulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_in = '0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic r0, r1, s0, s1, t0, t1;
  int checks = 0, errors = 0;
  int sel = 0, div = 4, pre = 2, dut_tx = 0;
  logic [7:0] code_v = 8'b10110010;
  logic [7:0] pend[$];
  bit q[$];
  bit cur_on = 0, cur_sig = 0, acc = 0;

  always #5 clk = ~clk;

  code_modulator #(.CODE_LEN(8), .CODE(8'b10110010), .CHIP_DIV(4), .PREAMBLE_BITS(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(v0),
    .data_ready(r0), .sig_out(s0), .tx_en(t0)
  );
  code_modulator #(.CODE_LEN(8), .CODE(8'b10110010), .CHIP_DIV(1), .PREAMBLE_BITS(0)) dut_fast (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(v1),
    .data_ready(r1), .sig_out(s1), .tx_en(t1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_bit(input bit b);
    for (int c = 0; c < 8; c++) repeat (div) q.push_back(code_v[7-c] ~^ b);
  endtask

  // One clock: check outputs against the model, apply inputs, advance the model at the edge.
  task automatic cycle(input bit v, input logic [7:0] d);
    bit rdy;
    rdy = !cur_on || q.size() == 0;
    data_in = d;
    v0 = (sel == 0) & v;
    v1 = (sel == 1) & v;
    if ((sel ? t1 : t0) === 1'b1) dut_tx++;
    check("sig_out", {31'd0, sel ? s1 : s0}, {31'd0, cur_sig});
    check("tx_en", {31'd0, sel ? t1 : t0}, {31'd0, cur_on});
    check("data_ready", {31'd0, sel ? r1 : r0}, {31'd0, rdy});
    @(posedge clk);
    acc = v && rdy;
    if (acc) begin
      if (!cur_on) repeat (pre) push_bit(1'b1);
      for (int i = 7; i >= 0; i--) push_bit(d[i]);
    end
    cur_on = q.size() > 0;
    cur_sig = cur_on ? q.pop_front() : 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    cur_on = 0;
    cur_sig = 0;
  endtask

  // Sends pend[] with valid held until each byte is taken, then drains the burst.
  task automatic run_bytes();
    int budget;
    budget = 5000;
    while (pend.size() > 0 && budget > 0) begin
      cycle(1'b1, pend[0]);
      if (acc) void'(pend.pop_front());
      budget--;
    end
    while (cur_on && budget > 0) begin
      cycle(1'b0, 8'h00);
      budget--;
    end
    if (budget == 0) check("timeout", 1, 0);
    repeat (3) cycle(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    int g, budget;
    do_reset();
    check("reset_tx", {31'd0, t0}, 0);
    check("reset_ready", {31'd0, r0}, 1);
    dut_tx = 0;
    pend.push_back(8'hA5);
    run_bytes();
    check("a5_len", dut_tx, 320);
    dut_tx = 0;
    pend.push_back(8'hFF);
    pend.push_back(8'h00);
    run_bytes();
    check("b2b_len", dut_tx, 576);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      g = $urandom_range(0, 300);
      repeat (g) cycle(1'b0, 8'h00);
      budget = 3000;
      acc = 0;
      while (!acc && budget > 0) begin
        cycle(1'b1, b);
        budget--;
      end
      if (budget == 0) check("rand_timeout", 1, 0);
    end
    run_bytes();
    acc = 0;
    while (!acc) cycle(1'b1, 8'h5A);
    repeat (99) cycle(1'b0, 8'h00);
    do_reset();
    check("midrst_sig", {31'd0, s0}, 0);
    check("midrst_tx", {31'd0, t0}, 0);
    check("midrst_ready", {31'd0, r0}, 1);
    dut_tx = 0;
    pend.push_back(8'h80);
    run_bytes();
    check("post_rst_len", dut_tx, 320);
    sel = 1;
    div = 1;
    pre = 0;
    dut_tx = 0;
    pend.push_back(8'h01);
    run_bytes();
    check("fast_len", dut_tx, 64);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
